// File: rtl/mem_loader.sv
// Program loader: packs a byte stream little-endian into 32-bit words and writes them to memory, then raises run.
// Latency: one WRITE cycle follows the edge that accepts the 4th (or last) byte of a word; peak 4 bytes per 5 cycles.
// Backpressure: in_ready is registered from state alone, high only in RECV. Optional zero-fill of the rest of memory: MEM_LOADER_CLEAR_EN.
module mem_loader #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic        W,
    output logic [31:0] realaddr,
    output logic [31:0] dout,
    output logic        run,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
`ifdef MEM_LOADER_CLEAR_EN
        S_CLEAR = 3'd3,
`endif
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t         state_q, state_nxt;
    logic [AW-1:0]  ptr_q, ptr_nxt;
    logic [1:0]     lane_q, lane_nxt;
    logic [31:0]    word_q, word_nxt;
    logic           last_q, last_nxt;
    logic           wr_nxt;
    logic [31:0]    addr_nxt, dat_nxt;

    logic [31:0]    assembled;
    logic [31:0]    ptr_ext, ptr_inc_ext;
    logic [AW-1:0]  ptr_inc;
    logic           ptr_at_top;

    assign assembled   = word_q | ({24'b0, in_byte} << {lane_q, 3'b000});
    assign ptr_inc     = ptr_q + AW'(1);
    assign ptr_ext     = {{(32-AW){1'b0}}, ptr_q};
    assign ptr_inc_ext = {{(32-AW){1'b0}}, ptr_inc};
    assign ptr_at_top  = (ptr_q == AW'(DEPTH - 1));

    always_comb begin
        state_nxt = state_q;
        ptr_nxt   = ptr_q;
        lane_nxt  = lane_q;
        word_nxt  = word_q;
        last_nxt  = last_q;
        wr_nxt    = 1'b0;
        addr_nxt  = realaddr;
        dat_nxt   = dout;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RECV;
                    ptr_nxt   = '0;
                    lane_nxt  = '0;
                    word_nxt  = '0;
                    last_nxt  = 1'b0;
                end
            end
            S_RECV: begin
                if (in_valid && in_ready) begin
                    word_nxt = assembled;
                    // Unfilled lanes stay zero because word_q is cleared per word.
                    if (lane_q == 2'd3 || in_last) begin
                        state_nxt = S_WRITE;
                        wr_nxt    = 1'b1;
                        addr_nxt  = ptr_ext;
                        dat_nxt   = assembled;
                        last_nxt  = in_last;
                    end else begin
                        lane_nxt = lane_q + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                if (last_q) begin
`ifdef MEM_LOADER_CLEAR_EN
                    if (ptr_at_top) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_CLEAR;
                        ptr_nxt   = ptr_inc;
                        wr_nxt    = 1'b1;
                        addr_nxt  = ptr_inc_ext;
                        dat_nxt   = '0;
                    end
`else
                    state_nxt = S_DONE;
`endif
                end else if (ptr_at_top) begin
                    // Memory full without an end-of-image marker: never wrap.
                    state_nxt = S_ERR;
                end else begin
                    state_nxt = S_RECV;
                    ptr_nxt   = ptr_inc;
                    lane_nxt  = '0;
                    word_nxt  = '0;
                end
            end
`ifdef MEM_LOADER_CLEAR_EN
            S_CLEAR: begin
                if (ptr_at_top) begin
                    state_nxt = S_DONE;
                end else begin
                    ptr_nxt  = ptr_inc;
                    wr_nxt   = 1'b1;
                    addr_nxt = ptr_inc_ext;
                    dat_nxt  = '0;
                end
            end
`endif
            default: ;
        endcase
    end

    // Status outputs are flops fed from next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            lane_q   <= '0;
            word_q   <= '0;
            last_q   <= 1'b0;
            in_ready <= 1'b0;
            W        <= 1'b0;
            realaddr <= '0;
            dout     <= '0;
            run      <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            ptr_q    <= ptr_nxt;
            lane_q   <= lane_nxt;
            word_q   <= word_nxt;
            last_q   <= last_nxt;
            in_ready <= (state_nxt == S_RECV);
            W        <= wr_nxt;
            realaddr <= addr_nxt;
            dout     <= dat_nxt;
            run      <= (state_nxt == S_DONE);
            busy     <= !(state_nxt == S_IDLE || state_nxt == S_DONE || state_nxt == S_ERR);
            err      <= (state_nxt == S_ERR);
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: vector table, hand-written corner sequences and random images vs. a packing model.
module tb_mem_loader;

    localparam int DEPTH = 32;
`ifdef MEM_LOADER_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_last;
    logic [7:0]  in_byte;
    logic        in_ready, W, run, busy, err;
    logic [31:0] realaddr, dout;

    mem_loader #(.DEPTH(DEPTH), .AW(5)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .W(W), .realaddr(realaddr), .dout(dout),
        .run(run), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Write monitor: sole writer of the logs below.
    int          cyc = 0;
    wq_t         wa_q, wd_q;
    int          wcyc_last = 0;
    int          run_rise_cyc = 0;
    int          w_consec = 0;
    logic        w_prev = 1'b0;
    logic        run_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (W === 1'b1) begin
            wa_q.push_back(realaddr);
            wd_q.push_back(dout);
            wcyc_last = cyc;
            if (w_prev === 1'b1) w_consec++;
        end
        w_prev = W;
        if (run === 1'b1 && run_prev !== 1'b1) run_rise_cyc = cyc;
        run_prev = run;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else passed++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_byte = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Starts and ends just after a falling edge; in_ready is stable there.
    task automatic send_byte(input logic [7:0] b, input bit last, input int gap, output bit ok);
        bit rdy;
        ok = 1'b0;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1; in_byte = b; in_last = last;
        for (int t = 0; t < 50 && !ok; t++) begin
            rdy = in_ready;
            @(posedge clk);
            ok = rdy;
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_done(output bit tmo);
        tmo = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (run === 1'b1 || err === 1'b1) begin
                tmo = 1'b0;
                break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_load(input bq_t b, input bit with_last, input int gapmode,
                            output int nacc, output int base, output int wc0, output bit tmo);
        bit ok;
        int gap;
        do_reset();
        base = wa_q.size();
        wc0  = w_consec;
        pulse_start();
        nacc = 0;
        for (int i = 0; i < b.size(); i++) begin
            gap = (gapmode == 2) ? int'($urandom_range(0, 2)) : gapmode;
            send_byte(b[i], with_last && (i == b.size() - 1), gap, ok);
            if (!ok) break;
            nacc++;
        end
        wait_done(tmo);
    endtask

    // Reference: bytes grouped four at a time, byte k of a group at bits 8k+7:8k.
    task automatic model(input bq_t b, input bit with_last, output wq_t ea, output wq_t ed,
                         output int nbytes);
        int nw;
        logic [31:0] w;
        ea = {}; ed = {};
        nbytes = b.size();
        if (!with_last && nbytes > 4 * DEPTH) nbytes = 4 * DEPTH;
        nw = with_last ? (nbytes + 3) / 4 : nbytes / 4;
        for (int i = 0; i < nw; i++) begin
            w = '0;
            for (int k = 0; k < 4; k++)
                if (4 * i + k < nbytes) w = w | (32'(b[4 * i + k]) << (8 * k));
            ea.push_back(32'(i));
            ed.push_back(w);
        end
        if (CLR && with_last)
            for (int a = nw; a < DEPTH; a++) begin
                ea.push_back(32'(a));
                ed.push_back(32'h0);
            end
    endtask

    task automatic verify(input string tag, input int base, input wq_t ea, input wq_t ed,
                          input bit exp_run, input int wc0);
        chk({tag, " nwrites"}, 32'(wa_q.size() - base), 32'(ea.size()));
        for (int i = 0; i < ea.size(); i++)
            if (base + i < wa_q.size()) begin
                chk({tag, " addr"}, wa_q[base + i], ea[i]);
                chk({tag, " data"}, wd_q[base + i], ed[i]);
            end
        chk({tag, " run"}, 32'(run), 32'(exp_run));
        chk({tag, " err"}, 32'(err), 32'(!exp_run));
        chk({tag, " in_ready"}, 32'(in_ready), 32'h0);
        chk({tag, " busy"}, 32'(busy), 32'h0);
        if (exp_run) chk({tag, " run_after_last_w"}, 32'(run_rise_cyc - wcyc_last), 32'h1);
`ifndef MEM_LOADER_CLEAR_EN
        chk({tag, " w_back_to_back"}, 32'(w_consec - wc0), 32'h0);
`endif
    endtask

    typedef struct {
        logic [7:0]  first;
        int          n;
        int          gap;
        int          exp_nw;
        logic [31:0] exp_w0;
        logic [31:0] exp_wl;
    } vec_t;

    initial begin
        vec_t        vt[5];
        bq_t         b;
        wq_t         ea, ed;
        int          nacc, base, wc0, nb, n0;
        bit          tmo, ok;
        logic [31:0] w;

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_byte = 8'h00;
        vt[0] = '{8'h01, 6, 0, CLR ? 32 : 2, 32'h04030201, CLR ? 32'h0 : 32'h00000605};
        vt[1] = '{8'h01, 6, 1, CLR ? 32 : 2, 32'h04030201, CLR ? 32'h0 : 32'h00000605};
        vt[2] = '{8'h10, 8, 1, CLR ? 32 : 2, 32'h13121110, CLR ? 32'h0 : 32'h17161514};
        vt[3] = '{8'hA0, 1, 0, CLR ? 32 : 1, 32'h000000A0, CLR ? 32'h0 : 32'h000000A0};
        vt[4] = '{8'hF0, 7, 1, CLR ? 32 : 2, 32'hF3F2F1F0, CLR ? 32'h0 : 32'h00F6F5F4};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", {25'b0, in_ready, W, run, busy, err, 2'b0},  32'h0);
        chk("reset_addr", realaddr, 32'h0);
        chk("reset_dout", dout, 32'h0);
        reset = 1'b0;

        // Single word 0x12345678
        b = {8'h78, 8'h56, 8'h34, 8'h12};
        run_load(b, 1'b1, 0, nacc, base, wc0, tmo);
        chk("one_word timeout", 32'(tmo), 32'h0);
        model(b, 1'b1, ea, ed, nb);
        chk("one_word data_lit", (wa_q.size() > base) ? wd_q[base] : 32'hx, 32'h12345678);
        verify("one_word", base, ea, ed, 1'b1, wc0);

        // Vector table
        for (int v = 0; v < 5; v++) begin
            b = {};
            for (int i = 0; i < vt[v].n; i++) b.push_back(vt[v].first + 8'(i));
            run_load(b, 1'b1, vt[v].gap, nacc, base, wc0, tmo);
            chk("tbl timeout", 32'(tmo), 32'h0);
            chk("tbl nacc", 32'(nacc), 32'(vt[v].n));
            chk("tbl nwrites", 32'(wa_q.size() - base), 32'(vt[v].exp_nw));
            if (wa_q.size() > base) begin
                chk("tbl w0", wd_q[base], vt[v].exp_w0);
                chk("tbl wlast", wd_q[wa_q.size() - 1], vt[v].exp_wl);
                chk("tbl addr_last", wa_q[wa_q.size() - 1], 32'(vt[v].exp_nw - 1));
            end
            chk("tbl run", 32'(run), 32'h1);
            chk("tbl run_after_last_w", 32'(run_rise_cyc - wcyc_last), 32'h1);
        end

        // Overflow: 129 bytes, no last
        b = {};
        for (int i = 0; i < 129; i++) b.push_back(8'(i * 3 + 1));
        run_load(b, 1'b0, 0, nacc, base, wc0, tmo);
        chk("ovf timeout", 32'(tmo), 32'h0);
        chk("ovf nacc", 32'(nacc), 32'd128);
        model(b, 1'b0, ea, ed, nb);
        verify("ovf", base, ea, ed, 1'b0, wc0);

        // Asynchronous reset in the middle of the third word
        do_reset();
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(8'(8'h40 + i), 1'b0, 0, ok);
        chk("midrst pre_addr", realaddr, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("midrst flags", {27'b0, in_ready, W, run, busy, err}, 32'h0);
        chk("midrst addr", realaddr, 32'h0);
        chk("midrst dout", dout, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        base = wa_q.size();
        wc0  = w_consec;
        pulse_start();
        b = {8'hC1, 8'hC2, 8'hC3, 8'hC4};
        for (int i = 0; i < 4; i++) send_byte(b[i], i == 3, 0, ok);
        wait_done(tmo);
        chk("midrst timeout", 32'(tmo), 32'h0);
        model(b, 1'b1, ea, ed, nb);
        verify("midrst", base, ea, ed, 1'b1, wc0);

        // start during RECV and during DONE is ignored
        do_reset();
        base = wa_q.size();
        wc0  = w_consec;
        pulse_start();
        send_byte(8'h78, 1'b0, 0, ok);
        send_byte(8'h56, 1'b0, 0, ok);
        pulse_start();
        chk("start_recv busy", 32'(busy), 32'h1);
        chk("start_recv in_ready", 32'(in_ready), 32'h1);
        send_byte(8'h34, 1'b0, 1, ok);
        send_byte(8'h12, 1'b1, 0, ok);
        wait_done(tmo);
        chk("start_recv timeout", 32'(tmo), 32'h0);
        b = {8'h78, 8'h56, 8'h34, 8'h12};
        model(b, 1'b1, ea, ed, nb);
        verify("start_recv", base, ea, ed, 1'b1, wc0);
        n0 = wa_q.size();
        pulse_start();
        repeat (5) @(negedge clk);
        chk("start_done run", 32'(run), 32'h1);
        chk("start_done no_write", 32'(wa_q.size() - n0), 32'h0);
        chk("start_done in_ready", 32'(in_ready), 32'h0);

        // Random images with random valid gaps
        for (int r = 0; r < 10; r++) begin
            b = {};
            nb = $urandom_range(1, 4 * DEPTH);
            for (int i = 0; i < nb; i++) b.push_back(8'($urandom));
            run_load(b, 1'b1, 2, nacc, base, wc0, tmo);
            chk("rand timeout", 32'(tmo), 32'h0);
            chk("rand nacc", 32'(nacc), 32'(nb));
            model(b, 1'b1, ea, ed, nb);
            verify("rand", base, ea, ed, 1'b1, wc0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
# mem_loader

Program loader that fills the unified instruction/data memory from a byte stream before the processor starts. It accepts bytes over a valid/ready handshake, packs them little-endian into 32-bit words, and writes them through the memory write port (`W`, `realaddr`, `dout`). The processor drives this same port during normal execution. When loading finishes, it raises `run` to release the core; the top level muxes the memory port from the loader while `run` is low.

## Interface
- `DEPTH`, 32, memory size in words (matches the 5-bit memory address).
- `AW`, 5, word-address width, equal to clog2(DEPTH).

- `clk`  in  1  system clock; all activity on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a load; sampled in IDLE only.
- `in_byte`  in  8  stream data byte.
- `in_valid`  in  1  `in_byte` is valid.
- `in_last`  in  1  qualifies `in_byte` as the final byte of the image.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `W`  out  1  memory write strobe, one cycle per word.
- `realaddr`  out  32  word address; bits [31:AW] are always 0.
- `dout`  out  32  write data.
- `run`  out  1  level; processor enable once load completes.
- `busy`  out  1  high in every state except IDLE, DONE and ERR.
- `err`  out  1  sticky overflow flag.

## Operation
- States: IDLE, RECV, WRITE, CLEAR (only with macro), DONE, ERR.
- IDLE: waits for `start`; on `start`=1, clear the word pointer and byte lane, then go to RECV.
- RECV:
  - `in_ready`=1.
  - A byte is accepted when `in_valid` & `in_ready`; it is stored in lane `k` at bits [8k+7:8k], and `k` increments.
  - After lane 3, or after any byte accepted with `in_last`=1, go to WRITE.
  - When `in_last` ends a partial word, the unfilled lanes are 0.
- WRITE:
  - `W`=1, `realaddr`=ptr, `dout`=assembled word, `in_ready`=0.
  - Next cycle:
    - if `in_last` was seen: go to CLEAR (macro) or DONE;
    - else if ptr==DEPTH-1: go to ERR;
    - else go to RECV with ptr+1 and the lane/word cleared.
- DONE: `run`=1, held until reset; `start` is ignored.
- ERR: `err`=1, `run`=0, `in_ready`=0; held until reset.
- `start` outside IDLE is ignored.
- The pointer never wraps. Bytes offered in any state other than RECV are not accepted.

## Timing
- Reset values: state IDLE; `in_ready`, `W`, `run`, `busy`, `err` all 0; `realaddr` and `dout` both 0. Reset takes effect immediately and asynchronously, including mid-load. Memory keeps its partial contents.
- `in_ready` is a registered function of state only; it does not depend on `in_valid`.
- Word latency: the edge accepting the 4th (or last) byte is followed by exactly one WRITE cycle.
- Peak throughput: 4 bytes per 5 cycles.
- `W` is never high for two consecutive cycles.
- `realaddr` and `dout` hold their last value when `W`=0.
- `run` rises on the first cycle of DONE. No write occurs in or after that cycle.
- Maximum image size is DEPTH×4 bytes. The DEPTH-th word must carry `in_last`, or the block enters ERR.

## Configuration
- `MEM_LOADER_CLEAR_EN` defined:
  - After the final WRITE, CLEAR writes 0 to every address ptr+1 through DEPTH-1, one per cycle with `W`=1, then enters DONE.
  - If the final word was at DEPTH-1, go directly to DONE.
  - `busy`=1 during CLEAR.
- Not defined: the CLEAR state is not compiled in. WRITE of the last word goes straight to DONE, and memory above the image is untouched.

## Test plan
- Reset, `start`, then bytes 0x78,0x56,0x34,0x12 with `in_last` on the 4th -> one `W` pulse, `realaddr`=0, `dout`=0x12345678, `run`=1 on the next cycle.
- 6 bytes 01..06, `in_last` on 06 -> writes 0x04030201 @0 and 0x00000605 @1. With the macro: 30 further zero writes @2..31, then `run`.
- `in_valid` toggling every other cycle during a 2-word load -> words are identical to the gapless case; each `W` is exactly 1 cycle; no byte is lost or duplicated.
- 129 bytes with no `in_last` -> 32 writes @0..31, then `err`=1, `in_ready`=0, `run`=0; the 129th byte is never accepted.
- Assert `reset` mid-word (after 2 bytes) -> all outputs 0 asynchronously. Then `start` plus a 4-byte load -> write @0 with only the new bytes.
- `start` pulsed during RECV and during DONE -> ignored; pointer and `run` are unchanged.
